user_bram_arbiter: RTL and testbench

Shares the single-port user-project BRAM (mprjram window, 0x3800_0000) among three requesters: the Wishbone slave path from the management CPU (requester 0), the FIR engine data mover (requester 1) and the matrix-multiply engine data mover (requester 2). It grants one access per cycle with round-robin fairness, supports bounded locked bursts, and routes read data back to the issuing requester after a fixed BRAM read latency. It sits between the requester-side adapters and the BRAM macro inside user_proj_example.

---
 rtl/user_bram_arbiter.sv | 150 +++++++++++++++
 tb/tb_user_bram_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/user_bram_arbiter.sv
// Round-robin arbiter sharing the user BRAM among CPU, FIR and MM movers.
// Define BRAM_ARB_CPU_PRIO_EN to give requester 0 (CPU) strict priority.
module user_bram_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int READ_LAT  = 1,
  parameter int MAX_BURST = 16
) (
  input  logic                  axis_clk,
  input  logic                  axis_rst_n,
  input  logic [2:0]            req_i,
  input  logic [2:0]            lock_i,
  input  logic [2:0]            we_i,
  input  logic [11:0]           wstrb_i,
  input  logic [3*ADDR_W-1:0]   addr_i,
  input  logic [95:0]           wdata_i,
  output logic [2:0]            gnt_o,
  output logic [2:0]            rvalid_o,
  output logic [31:0]           rdata_o,
  output logic                  bram_en,
  output logic [3:0]            bram_we,
  output logic [ADDR_W-1:0]     bram_addr,
  output logic [31:0]           bram_wdata,
  input  logic [31:0]           bram_rdata
);

  typedef enum logic {IDLE, LOCKED} state_t;
  localparam int CW = $clog2(MAX_BURST + 1);

  state_t          state;
  logic [1:0]      owner;
  logic [1:0]      rr_last;
  logic [CW-1:0]   beat_cnt;
  logic [2:0]      hold_off;
  logic [2:0]      cand;
  logic [2:0]      pick;
  logic [2:0]      gnt;
  logic [1:0]      gidx;
  logic            acc;

  logic [READ_LAT-1:0] pv;
  logic [1:0]          pid [READ_LAT];

  function automatic logic [2:0] rr_pick(
    input logic [2:0] c,
    input logic [1:0] last
  );
    logic [2:0] g;
    logic [1:0] idx;
    g   = 3'b000;
    idx = last;
    for (int k = 0; k < 3; k++) begin
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      if (g == 3'b000 && c[idx]) g[idx] = 1'b1;
    end
    return g;
  endfunction

  // hold_off keeps a burst-expired owner from winning straight back
  always_comb begin
    cand = req_i & ~hold_off;
    if (cand == 3'b000) cand = req_i;
`ifdef BRAM_ARB_CPU_PRIO_EN
    pick = cand[0] ? 3'b001 : rr_pick(cand & 3'b110, rr_last);
`else
    pick = rr_pick(cand, rr_last);
`endif
    gnt = 3'b000;
    if (axis_rst_n) begin
      if (state == IDLE) gnt = pick;
      else if (req_i[owner]) gnt = 3'b001 << owner;
    end
  end

  always_comb begin
    gidx = 2'd0;
    unique case (1'b1)
      gnt[0]:  gidx = 2'd0;
      gnt[1]:  gidx = 2'd1;
      gnt[2]:  gidx = 2'd2;
      default: gidx = 2'd0;
    endcase
  end

  assign acc        = |gnt;
  assign gnt_o      = gnt;
  assign bram_en    = acc;
  assign bram_addr  = acc ? addr_i[int'(gidx)*ADDR_W +: ADDR_W] : '0;
  assign bram_wdata = acc ? wdata_i[int'(gidx)*32 +: 32] : '0;
  assign bram_we    = (acc && we_i[gidx]) ? wstrb_i[int'(gidx)*4 +: 4] : 4'b0000;

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state    <= IDLE;
      owner    <= 2'd0;
      rr_last  <= 2'd2;
      beat_cnt <= '0;
      hold_off <= 3'b000;
    end else begin
      hold_off <= 3'b000;
      unique case (state)
        IDLE: begin
          if (acc) begin
            rr_last <= gidx;
            if (lock_i[gidx]) begin
              state    <= LOCKED;
              owner    <= gidx;
              beat_cnt <= CW'(1);
            end
          end
        end
        LOCKED: begin
          if (acc) beat_cnt <= beat_cnt + 1'b1;
          if (!req_i[owner] || !lock_i[owner]) begin
            state    <= IDLE;
            beat_cnt <= '0;
          end else if (beat_cnt == CW'(MAX_BURST - 1)) begin
            state    <= IDLE;
            beat_cnt <= '0;
            hold_off <= 3'b001 << owner;
          end
`ifdef BRAM_ARB_CPU_PRIO_EN
          else if (req_i[0] && owner != 2'd0) begin
            state    <= IDLE;
            beat_cnt <= '0;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      pv <= '0;
      for (int i = 0; i < READ_LAT; i++) pid[i] <= 2'd0;
    end else begin
      pv[0]  <= acc & ~we_i[gidx];
      pid[0] <= gidx;
      for (int i = 1; i < READ_LAT; i++) begin
        pv[i]  <= pv[i-1];
        pid[i] <= pid[i-1];
      end
    end
  end

  assign rvalid_o = pv[READ_LAT-1] ? (3'b001 << pid[READ_LAT-1]) : 3'b000;
  assign rdata_o  = pv[READ_LAT-1] ? bram_rdata : 32'h0;

endmodule

// File: tb/tb_user_bram_arbiter.sv
// Scoreboard bench for user_bram_arbiter with a behavioural BRAM.
// Covers BRAM_ARB_CPU_PRIO_EN when the bench is built with it defined.
module tb_user_bram_arbiter;

  localparam int AW = 10;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [2:0]    req = '0, lock = '0, we = '0;
  logic [11:0]   wstrb = '0;
  logic [3*AW-1:0] addr = '0;
  logic [95:0]   wdata = '0;

  logic [2:0]    gnt, rvalid, gnt2, rvalid2;
  logic [31:0]   rdata, rdata2, bwdata, bwdata2;
  logic          ben, ben2;
  logic [3:0]    bwe, bwe2;
  logic [AW-1:0] baddr, baddr2;
  logic [31:0]   brdata = '0, r2a = '0, r2b = '0;

  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_a = '0;
  logic [31:0]   pl_d = '0;
  logic [31:0]   mem [1024];
  logic [31:0]   ref_mem [1024];

  exp_t sbq[$];
  bit   sb_en = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  user_bram_arbiter #(.ADDR_W(AW), .READ_LAT(1), .MAX_BURST(16)) dut (
    .axis_clk(clk), .axis_rst_n(rst_n),
    .req_i(req), .lock_i(lock), .we_i(we), .wstrb_i(wstrb),
    .addr_i(addr), .wdata_i(wdata),
    .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
    .bram_en(ben), .bram_we(bwe), .bram_addr(baddr),
    .bram_wdata(bwdata), .bram_rdata(brdata)
  );

  user_bram_arbiter #(.ADDR_W(AW), .READ_LAT(2), .MAX_BURST(16)) dut2 (
    .axis_clk(clk), .axis_rst_n(rst_n),
    .req_i(req), .lock_i(lock), .we_i(we), .wstrb_i(wstrb),
    .addr_i(addr), .wdata_i(wdata),
    .gnt_o(gnt2), .rvalid_o(rvalid2), .rdata_o(rdata2),
    .bram_en(ben2), .bram_we(bwe2), .bram_addr(baddr2),
    .bram_wdata(bwdata2), .bram_rdata(r2b)
  );

  always @(posedge clk) begin
    if (pl_en) mem[pl_a] <= pl_d;
    else if (ben)
      for (int b = 0; b < 4; b++)
        if (bwe[b]) mem[baddr][8*b +: 8] <= bwdata[8*b +: 8];
    if (ben) brdata <= mem[baddr];
    if (ben2) r2a <= mem[baddr2];
    r2b <= r2a;
  end

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rvalid !== 3'b000) begin
      if (sbq.size() == 0) begin
        chk("rv_unexp", 32'(rvalid), 32'h0);
      end else begin
        e = sbq.pop_front();
        chk("rv_id", 32'(rvalid), 32'(3'b001 << e.id));
        chk("rdata", rdata, e.data);
      end
    end
  end

  task automatic set_rq(input int i, input logic r, input logic l,
                        input logic w, input logic [3:0] s,
                        input logic [AW-1:0] a, input logic [31:0] d);
    req[i]             = r;
    lock[i]            = l;
    we[i]              = w;
    wstrb[4*i +: 4]    = s;
    addr[AW*i +: AW]   = a;
    wdata[32*i +: 32]  = d;
  endtask

  task automatic tick(input string tag, input logic [2:0] eg);
    logic [2:0]    acc;
    logic [AW-1:0] a;
    #1;
    chk(tag, 32'(gnt), 32'(eg));
    acc = eg & req;
    chk({tag, "_en"}, 32'(ben), 32'(|acc));
    if (acc == 3'b000) chk({tag, "_we0"}, 32'(bwe), 32'h0);
    for (int i = 0; i < 3; i++) begin
      if (acc[i]) begin
        a = addr[AW*i +: AW];
        chk({tag, "_addr"}, 32'(baddr), 32'(a));
        if (we[i]) begin
          chk({tag, "_bwe"}, 32'(bwe), 32'(wstrb[4*i +: 4]));
          chk({tag, "_wd"}, bwdata, wdata[32*i +: 32]);
          for (int b = 0; b < 4; b++)
            if (wstrb[4*i+b]) ref_mem[a][8*b +: 8] = wdata[32*i+8*b +: 8];
        end else begin
          chk({tag, "_rwe"}, 32'(bwe), 32'h0);
          if (sb_en) sbq.push_back('{id: 2'(i), data: ref_mem[a]});
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
    pl_en = 1'b1;
    pl_a  = a;
    pl_d  = d;
    ref_mem[a] = d;
    @(posedge clk);
    #1;
    pl_en = 1'b0;
  endtask

  task automatic drain();
    req = 3'b000;
    for (int k = 0; k < 8 && sbq.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    chk("drain", 32'(sbq.size()), 32'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int fir_k, mm_k;
    logic mm_p, cpu_p;
    logic [2:0] eg;
    logic [2:0] seq6 [7];

    @(posedge clk);
    #1;
    preload(10'h010, 32'hDEADBEEF);
    preload(10'h020, 32'hAAAAAAAA);
    preload(10'h030, 32'h30303030);
    preload(10'h031, 32'h31313131);
    preload(10'h032, 32'h32323232);
    for (int k = 0; k < 6; k++) preload(10'(10'h040 + k), 32'hC0DE0000 + k);

    req = 3'b111;
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_rv", 32'(rvalid), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_en", 32'(ben), 32'h0);
    chk("rst_we", 32'(bwe), 32'h0);
    chk("rst_addr", 32'(baddr), 32'h0);
    chk("rst_wd", bwdata, 32'h0);
    req = 3'b000;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // single CPU read
    set_rq(0, 1, 0, 0, 4'h0, 10'h010, 32'h0);
    tick("t1_gnt", 3'b001);
    req = 3'b000;
    tick("t1_idle", 3'b000);
    drain();

    // three-way rotation from reset
    do_reset();
    set_rq(0, 1, 0, 0, 4'h0, 10'h030, 32'h0);
    set_rq(1, 1, 0, 0, 4'h0, 10'h031, 32'h0);
    set_rq(2, 1, 0, 0, 4'h0, 10'h032, 32'h0);
    for (int c = 0; c < 6; c++) tick("t2_rr", 3'b001 << (c % 3));
    req = 3'b000;
    tick("t2_idle", 3'b000);
    drain();

    // FIR locked write burst capped at MAX_BURST with MM waiting
    fir_k = 0;
    mm_p  = 1'b1;
    for (int c = 0; c < 21; c++) begin
      set_rq(1, fir_k < 20, 1, 1, 4'hF, 10'(10'h100 + fir_k),
             32'hF1000000 + fir_k);
      set_rq(2, mm_p, 0, 0, 4'h0, 10'h040, 32'h0);
      eg = (c == 16) ? 3'b100 : 3'b010;
      tick("t3_burst", eg);
      if (eg[1]) fir_k++;
      if (eg[2]) mm_p = 1'b0;
    end
    req = 3'b000;
    tick("t3_rel", 3'b000);
    set_rq(0, 1, 0, 0, 4'h0, 10'h111, 32'h0);
    tick("t3_rdbk", 3'b001);
    req = 3'b000;
    drain();

    // partial-strobe write then read back
    set_rq(0, 1, 0, 1, 4'b0011, 10'h020, 32'h12345678);
    tick("t4_wr", 3'b001);
    set_rq(0, 1, 0, 0, 4'h0, 10'h020, 32'h0);
    tick("t4_rd", 3'b001);
    req = 3'b000;
    tick("t4_idle", 3'b000);
    drain();

    // reset one cycle after a read is accepted
    sb_en = 1'b0;
    set_rq(0, 1, 0, 0, 4'h0, 10'h010, 32'h0);
    tick("t5_acc", 3'b001);
    req   = 3'b000;
    rst_n = 1'b0;
    #1;
    chk("t5_rv", 32'(rvalid), 32'h0);
    chk("t5_rv2", 32'(rvalid2), 32'h0);
    chk("t5_rd2", rdata2, 32'h0);
    chk("t5_en2", 32'(ben2), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick("t5_post", 3'b000);
      #1;
      chk("t5_prv2", 32'(rvalid2), 32'h0);
      chk("t5_prd2", rdata2, 32'h0);
    end
    sb_en = 1'b1;

    // MM locked burst with CPU arriving at beat 3
`ifdef BRAM_ARB_CPU_PRIO_EN
    seq6 = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b100, 3'b100, 3'b100};
`else
    seq6 = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b001};
`endif
    mm_k  = 0;
    cpu_p = 1'b0;
    for (int c = 0; c < 7; c++) begin
      if (c == 2) cpu_p = 1'b1;
      set_rq(2, mm_k < 6, mm_k < 5, 0, 4'h0, 10'(10'h040 + mm_k), 32'h0);
      set_rq(0, cpu_p, 0, 0, 4'h0, 10'h010, 32'h0);
      tick("t6_seq", seq6[c]);
      if (seq6[c][2]) mm_k++;
      if (seq6[c][0]) cpu_p = 1'b0;
    end
    req = 3'b000;
    tick("t6_idle", 3'b000);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
